// File: rtl/apb_2_axi_lite.sv
// APB slave to AXI4-Lite master bridge: each APB transfer becomes one AXI-Lite
// write (AW+W+B) or read (AR+R); pready is held off until the AXI response returns.
module apb_2_axi_lite #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [31:0]                   paddr,
  input  logic [2:0]                    pprot,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [AXI_DATA_WIDTH-1:0]     pwdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   pstrb,
  output logic                          pready,
  output logic [AXI_DATA_WIDTH-1:0]     prdata,
  output logic                          pslverr,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                state_q,   state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [2:0]                prot_q,    prot_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]         wstrb_q,   wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q,  wvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q,  w_done_d;
  logic                      bready_q,  bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q,  rready_d;
  logic                      pready_q,  pready_d;
  logic                      pslverr_q, pslverr_d;
  logic [AXI_DATA_WIDTH-1:0] prdata_q,  prdata_d;

  // SLVERR (2'b10) and DECERR (2'b11) map to an APB error; OKAY/EXOKAY do not.
  function automatic logic is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;

    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr[AXI_ADDR_WIDTH-1:0];
          prot_d  = pprot;
          wdata_d = pwdata;
          wstrb_d = pwrite ? pstrb : '1;
          if (pwrite) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; move on once both have handshaken.
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d  = 1'b0;
          pslverr_d = is_err(M_AXI_BRESP);
          pready_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d  = 1'b0;
          prdata_d  = M_AXI_RDATA;
          pslverr_d = is_err(M_AXI_RRESP);
          pready_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready        = pready_q;
  assign pslverr       = pslverr_q;
  assign prdata        = prdata_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = prot_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = prot_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_apb_2_axi_lite.sv
// Bench for apb_2_axi_lite: APB master driver, delay-configurable AXI-Lite slave
// model, and a scoreboard of expected APB completions and AXI request beats.
module tb_apb_2_axi_lite;

  logic        clk, rst;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  apb_2_axi_lite #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_prdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] prdata;
    int          lat;
  } done_t;

  int checks = 0, failures = 0, proto_err = 0;
  int cyc = 0;
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;

  logic [34:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [34:0] exp_ar[$];
  done_t       sb[$];
  vec_t        tbl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {47'd0, pready, pslverr, AWVALID, WVALID, BREADY, ARVALID, RREADY,
                           AWPROT, ARPROT, WSTRB}, 64'd0);
    check({name, "_addr"}, {AWADDR, ARADDR}, 64'd0);
    check({name, "_data"}, {prdata, WDATA}, 64'd0);
  endtask

  // AXI-Lite slave: each READY/VALID is raised after a configured number of cycles.
  initial begin
    int cnt = 0;
    AWREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (AWREADY) AWREADY = 1'b0;
      else if (!AWVALID) cnt = 0;
      else if (cnt >= cfg_aw_dly) begin AWREADY = 1'b1; cnt = 0; end
      else cnt++;
    end
  end

  initial begin
    int cnt = 0;
    WREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (WREADY) WREADY = 1'b0;
      else if (!WVALID) cnt = 0;
      else if (cnt >= cfg_w_dly) begin WREADY = 1'b1; cnt = 0; end
      else cnt++;
    end
  end

  initial begin
    int cnt = 0;
    ARREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ARREADY) ARREADY = 1'b0;
      else if (!ARVALID) cnt = 0;
      else if (cnt >= cfg_ar_dly) begin ARREADY = 1'b1; cnt = 0; end
      else cnt++;
    end
  end

  initial begin
    int cnt = 0;
    logic hs;
    BVALID = 1'b0; BRESP = 2'b00;
    forever begin
      @(negedge clk); hs = BVALID && BREADY;
      @(posedge clk); #1;
      if (hs) BVALID = 1'b0;
      else if (!BREADY) cnt = 0;
      else if (!BVALID) begin
        if (cnt >= cfg_b_dly) begin BVALID = 1'b1; BRESP = cfg_resp; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin
    int cnt = 0;
    logic hs;
    RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
    forever begin
      @(negedge clk); hs = RVALID && RREADY;
      @(posedge clk); #1;
      if (hs) RVALID = 1'b0;
      else if (!RREADY) cnt = 0;
      else if (!RVALID) begin
        if (cnt >= cfg_r_dly) begin RVALID = 1'b1; RRESP = cfg_resp; RDATA = cfg_rdata; cnt = 0; end
        else cnt++;
      end
    end
  end

  // Request-channel monitor: checks beat contents and VALID/pslverr protocol.
  initial begin
    logic aw_prev = 1'b0, w_prev = 1'b0, ar_prev = 1'b0;
    logic [34:0] a;
    logic [35:0] d;
    forever begin
      @(negedge clk);
      if (aw_prev && AWVALID) proto_err++;
      if (w_prev && WVALID) proto_err++;
      if (ar_prev && ARVALID) proto_err++;
      if (pslverr && !pready) proto_err++;
      aw_prev = AWVALID && AWREADY;
      w_prev  = WVALID && WREADY;
      ar_prev = ARVALID && ARREADY;
      if (AWVALID && AWREADY) begin
        aw_hs_cyc = cyc;
        if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin a = exp_aw.pop_front(); check("aw_beat", {29'd0, AWPROT, AWADDR}, {29'd0, a}); end
      end
      if (WVALID && WREADY) begin
        w_hs_cyc = cyc;
        if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin d = exp_w.pop_front(); check("w_beat", {28'd0, WSTRB, WDATA}, {28'd0, d}); end
      end
      if (ARVALID && ARREADY) begin
        ar_hs_cyc = cyc;
        if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else begin a = exp_ar.pop_front(); check("ar_beat", {29'd0, ARPROT, ARADDR}, {29'd0, a}); end
      end
    end
  end

  task automatic apb_xfer(input vec_t v);
    int t0, n;
    done_t e;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_resp = v.resp; cfg_rdata = v.rdata;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.data; pstrb = v.strb; pprot = v.prot;
    t0 = cyc;
    if (v.wr) begin
      exp_aw.push_back({v.prot, v.addr});
      exp_w.push_back({v.strb, v.data});
    end else exp_ar.push_back({v.prot, v.addr});
    sb.push_back('{v.exp_err, v.exp_prdata, v.exp_lat});
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pready && n < 40);
    e = sb.pop_front();
    if (!pready) check("pready_timeout", 64'd0, 64'd1);
    else begin
      check("pslverr", {63'd0, pslverr}, {63'd0, e.err});
      check("prdata", {32'd0, prdata}, {32'd0, e.prdata});
      check("latency", 64'(cyc - t0), 64'(e.lat));
      if (v.wr) begin
        check("aw_hs_cycle", 64'(aw_hs_cyc - t0), 64'(1 + v.aw_dly));
        check("w_hs_cycle", 64'(w_hs_cyc - t0), 64'(1 + v.w_dly));
      end else check("ar_hs_cycle", 64'(ar_hs_cyc - t0), 64'(1 + v.ar_dly));
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", {63'd0, pready}, 64'd0);
  endtask

  initial begin
    int n;
    vec_t rv;
    //           wr    addr          data          strb   prot    aw w b ar r  resp   rdata         err   prdata        lat
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h0,         1'b0, 32'h0,         3};
    tbl[1] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 3'b001, 0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 1'b0, 32'h1234_5678, 6};
    tbl[2] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h5, 3'b010, 2, 0, 0, 0, 0, 2'b10, 32'h0,         1'b1, 32'h1234_5678, 5};
    tbl[3] = '{1'b0, 32'h0000_008C, 32'h0,         4'hF, 3'b100, 0, 0, 0, 1, 0, 2'b11, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 4};
    tbl[4] = '{1'b0, 32'h0000_000C, 32'h0,         4'hF, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 3};
    tbl[5] = '{1'b1, 32'hFFFF_0100, 32'h0102_0304, 4'h8, 3'b111, 0, 1, 2, 0, 0, 2'b01, 32'h0,         1'b0, 32'h0BAD_CAFE, 6};
    tbl[6] = '{1'b0, 32'h8000_0040, 32'h0,         4'h0, 3'b011, 0, 0, 0, 0, 1, 2'b10, 32'h1111_2222, 1'b1, 32'h1111_2222, 4};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apb_xfer(tbl[i]);

    // Reset while the bridge waits for B: everything clears at once.
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 20; cfg_resp = 2'b00;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0040;
    pwdata = 32'h5555_AAAA; pstrb = 4'hF; pprot = 3'b000;
    exp_aw.push_back({3'b000, 32'h0000_0040});
    exp_w.push_back({4'hF, 32'h5555_AAAA});
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!BREADY && n < 20) begin @(negedge clk); n++; end
    check("reached_wr_resp", {63'd0, BREADY}, 64'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset_abort");
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("aw_w_queues_drained", 64'(exp_aw.size() + exp_w.size()), 64'd0);

    rv = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h8765_4321,
           1'b0, 32'h8765_4321, 3};
    apb_xfer(rv);

    repeat (2) @(negedge clk);
    check("protocol_violations", 64'(proto_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
